reg_wb_arbiter: RTL

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter_pkg.sv | 22 ++
 rtl/reg_wb_arbiter_rr_arb2.sv | 19 +
 rtl/reg_wb_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-file write-port definitions: widths, grant encoding and
// the request record handed from a writeback source to the write port.
package reg_wb_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    // Encoding of the last_grant register: which requester won most recently.
    localparam logic GNT_REQ0 = 1'b0;
    localparam logic GNT_REQ1 = 1'b1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    // Register 0 is hard-wired zero, so writes to it are swallowed.
    function automatic logic is_live_addr(input logic [ADDR_WIDTH-1:0] a);
        return a != '0;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone valid requester always wins, on a
// conflict the requester that did not win last time wins.
module rr_arb2
    import reg_wb_arbiter_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // One-hot grant from the valids and the round-robin pointer.
    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = (last_grant_i == GNT_REQ0) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: merges the ALU (req0) and load (req1)
// writeback streams onto one registered write port, round-robin on conflict.
// Optional macro WB_PERF_CNT_EN adds grant and conflict counters.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_waddr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_waddr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  idle
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]           grant0_cnt,
    output logic [31:0]           grant1_cnt,
    output logic [31:0]           conflict_cnt
`endif
);

    logic                  last_grant_q, last_grant_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [1:0] arb_grant;
    logic [1:0] gnt;
    logic       xfer;
    wb_req_t    sel;

    rr_arb2 u_arb (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant)
    );

    // Readiness is suppressed in reset so nothing is accepted there.
    always_comb begin
        gnt  = rst ? 2'b00 : arb_grant;
        xfer = |gnt;
        sel  = gnt[1] ? wb_req_t'{addr: req1_waddr, data: req1_wdata}
                      : wb_req_t'{addr: req0_waddr, data: req0_wdata};
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Next state of the write port and round-robin pointer.
    always_comb begin
        wen_d        = xfer && is_live_addr(sel.addr);
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        if (wen_d) begin
            waddr_d = sel.addr;
            wdata_d = sel.data;
        end
        if (xfer) begin
            last_grant_d = gnt[1] ? GNT_REQ1 : GNT_REQ0;
        end
    end

    // Write-port register; reset leaves req0 favoured on the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            last_grant_q <= GNT_REQ1;
        end else begin
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign idle  = !req0_valid && !req1_valid && !wen_q;

`ifdef WB_PERF_CNT_EN
    logic [31:0] grant0_cnt_q, grant1_cnt_q, conflict_cnt_q;

    // Event counters; plain 32-bit adds wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_cnt_q   <= '0;
            grant1_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (gnt[0])                    grant0_cnt_q   <= grant0_cnt_q + 32'd1;
            if (gnt[1])                    grant1_cnt_q   <= grant1_cnt_q + 32'd1;
            if (req0_valid && req1_valid)  conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign grant0_cnt   = grant0_cnt_q;
    assign grant1_cnt   = grant1_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
